// File: rtl/adder_inverse_if.sv
// Valid/ready bus for the operand-recovery block.
// The master drives the sum/operand pair and consumes the result.
interface adder_inverse_if;
  logic [6:0] s;
  logic [5:0] y;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] x;
  logic       err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output s, y, in_valid, out_ready,
    input  in_ready, x, err, out_valid
  );

  modport slave (
    input  s, y, in_valid, out_ready,
    output in_ready, x, err, out_valid
  );
endinterface

// File: rtl/adder_inverse.sv
// Recovers x = s - y from a 7-bit sum and 6-bit operand, one bit per clock, LSB first.
// err flags pairs that no 6-bit + 6-bit addition can produce.
module adder_inverse (
  input  logic         clk,
  input  logic         rst,
  adder_inverse_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [6:0] s_q, s_d, y_q, y_d, d_q, d_d;
  logic [2:0] i_q, i_d;
  logic       b_q, b_d;
  logic [5:0] x_q, x_d;
  logic       err_q, err_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       diff_bit, borrow_nxt;

  always_comb begin
    diff_bit   = s_q[i_q] ^ y_q[i_q] ^ b_q;
    borrow_nxt = (~s_q[i_q] & y_q[i_q]) | (~(s_q[i_q] ^ y_q[i_q]) & b_q);

    state_d     = state_q;
    s_d         = s_q;
    y_d         = y_q;
    d_d         = d_q;
    i_d         = i_q;
    b_d         = b_q;
    x_d         = x_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d        = bus.s;
          y_d        = {1'b0, bus.y};
          i_d        = 3'd0;
          b_d        = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        d_d[i_q] = diff_bit;
        b_d      = borrow_nxt;
        i_d      = i_q + 3'd1;
        // Final bit: d[6] and the last borrow come from this edge's computation.
        if (i_q == 3'd6) begin
          x_d         = d_q[5:0];
          err_d       = borrow_nxt | diff_bit;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      i_q         <= '0;
      b_q         <= 1'b0;
      x_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      y_q         <= y_d;
      d_q         <= d_d;
      i_q         <= i_d;
      b_q         <= b_d;
      x_q         <= x_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.err       = err_q;
endmodule
